ram_line_ctrl: RTL and testbench

- Single-line buffered controller sitting directly upstream of the external-RAM model; the CPU/bus side sees single-word transfers.
- RAM side speaks the 8-word wrapping burst protocol: critical word first, beat k = word (addr[2:0]+k) mod 8.
- Holds one 8-word line buffer with tag. Read hits are served locally. Writes are read-modify-write of the whole line, written back by an 8-beat burst.

---
 rtl/ram_line_ctrl.sv | 153 +++++++++++++++
 tb/tb_ram_line_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_line_ctrl.sv
// Single-line buffered controller in front of an 8-word wrapping-burst RAM.
// Optional CRITICAL_WORD_FIRST_EN acks a read miss as soon as the critical word arrives.
module ram_line_ctrl #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stb,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          ack,
    output logic          ram_stb,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_dout,
    input  logic [DW-1:0] ram_din,
    input  logic          ram_ack
);

    typedef enum logic [2:0] {IDLE, FILL, MERGE, WBACK, DONE} state_t;

    state_t        state_reg;
    logic [2:0]    beat_reg;
    logic          valid_reg;
    logic [AW-4:0] tag_reg;
    logic [DW-1:0] line_buf [0:7];

    logic [2:0]    word_idx;
    logic [2:0]    beat_idx;
    logic          hit;
    logic          buf_we;
    logic [2:0]    buf_widx;
    logic [DW-1:0] buf_wdata;

    assign word_idx = addr[2:0];
    assign beat_idx = word_idx + beat_reg;
    assign hit      = valid_reg && (tag_reg == addr[AW-1:3]);
    // Write-back beat data follows the beat counter so it is ready before each ram_ack.
    assign ram_dout = line_buf[beat_idx];

    always_comb begin
        buf_we    = 1'b0;
        buf_widx  = beat_idx;
        buf_wdata = ram_din;
        if (!rst) begin
            if (state_reg == FILL && ram_ack) begin
                buf_we = 1'b1;
            end else if (state_reg == MERGE) begin
                buf_we    = 1'b1;
                buf_widx  = word_idx;
                buf_wdata = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_widx] <= buf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= 3'd0;
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            ack       <= 1'b0;
            ram_stb   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            data_out  <= '0;
        end else begin
            ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (stb) begin
                        if (hit && !we) begin
                            data_out  <= line_buf[word_idx];
                            ack       <= 1'b1;
                            state_reg <= DONE;
                        end else if (hit) begin
                            state_reg <= MERGE;
                        end else begin
                            state_reg <= FILL;
                            ram_stb   <= 1'b1;
                            ram_we    <= 1'b0;
                            ram_addr  <= addr;
                            beat_reg  <= 3'd0;
                        end
                    end
                end
                FILL: begin
                    if (ram_ack) begin
                        ram_stb  <= 1'b0;
                        beat_reg <= beat_reg + 3'd1;
`ifdef CRITICAL_WORD_FIRST_EN
                        if (!we && beat_reg == 3'd0) begin
                            data_out <= ram_din;
                            ack      <= 1'b1;
                        end
`endif
                        if (beat_reg == 3'd7) begin
                            valid_reg <= 1'b1;
                            tag_reg   <= addr[AW-1:3];
                            beat_reg  <= 3'd0;
                            if (we) begin
                                state_reg <= MERGE;
                            end else begin
`ifdef CRITICAL_WORD_FIRST_EN
                                state_reg <= IDLE;
`else
                                data_out  <= line_buf[word_idx];
                                ack       <= 1'b1;
                                state_reg <= DONE;
`endif
                            end
                        end
                    end
                end
                MERGE: begin
                    state_reg <= WBACK;
                    ram_stb   <= 1'b1;
                    ram_we    <= 1'b1;
                    ram_addr  <= addr;
                    beat_reg  <= 3'd0;
                end
                WBACK: begin
                    if (ram_ack) begin
                        ram_stb  <= 1'b0;
                        beat_reg <= beat_reg + 3'd1;
                        if (beat_reg == 3'd7) begin
                            beat_reg  <= 3'd0;
                            ram_we    <= 1'b0;
                            ack       <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_ctrl.sv
// Random and directed checks of ram_line_ctrl against a word-level memory model
// and a one-line cache reference; a burst RAM model with random beat gaps drives the RAM side.
module tb_ram_line_ctrl;

    localparam int AW = 22;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          ack;
    logic          ram_stb;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] ram_din;
    logic          ram_ack;

    ram_line_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .ram_stb  (ram_stb),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din),
        .ram_ack  (ram_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_total = 0;
    int txn_count = 0;
    int stb_viol = 0;

    // RAM model state
    logic [DW-1:0] ram_mem [logic [AW-1:0]];
    logic          busy;
    int            beat_k;
    logic [AW-1:0] b_addr;
    logic          b_we;
    logic          stray;
    int            beat0_cyc;
    int            last_cyc;
    logic [AW-1:0] burst_addr_q [$];
    logic          burst_we_q [$];
    logic [DW-1:0] wbeat_q [$];

    // Reference: what the CPU should observe, plus which line is buffered
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          ref_valid;
    logic [AW-4:0] ref_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {10'b0, a};
        return 32'hF8701E0F ^ (x * 32'h9E3779B1);
    endfunction

    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return pattern(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pattern(a);
    endfunction

    initial begin : ram_model
        logic [AW-1:0] idx;
        ram_ack = 1'b0;
        ram_din = '0;
        busy    = 1'b0;
        beat_k  = 0;
        b_addr  = '0;
        b_we    = 1'b0;
        beat0_cyc = -1;
        last_cyc  = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                ram_ack = 1'b0;
                busy    = 1'b0;
                beat_k  = 0;
            end else begin
                if (ram_ack) begin
                    ram_ack = 1'b0;
                    if (busy) begin
                        if (beat_k == 0) beat0_cyc = cyc;
                        beat_k++;
                        if (beat_k == 8) begin
                            busy     = 1'b0;
                            last_cyc = cyc;
                        end
                    end
                end
                if (!busy && ram_stb) begin
                    busy   = 1'b1;
                    b_addr = ram_addr;
                    b_we   = ram_we;
                    beat_k = 0;
                    burst_addr_q.push_back(ram_addr);
                    burst_we_q.push_back(ram_we);
                end else if (busy && beat_k > 0 && ram_stb) begin
                    stb_viol++;
                end
                if (busy && $urandom_range(0, 3) != 0) begin
                    idx = {b_addr[AW-1:3], b_addr[2:0] + beat_k[2:0]};
                    if (b_we) begin
                        ram_mem[idx] = ram_dout;
                        wbeat_q.push_back(ram_dout);
                    end else begin
                        ram_din = ram_read(idx);
                    end
                    ram_ack = 1'b1;
                end else if (!busy && stray) begin
                    ram_din = 32'hDEADBEEF;
                    ram_ack = 1'b1;
                    stray   = 1'b0;
                end
            end
        end
    end

    initial begin : ack_monitor
        forever begin
            @(negedge clk);
            if (ack) ack_total++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (busy) check_val("idle_timeout", 64'(busy), 64'd0);
    endtask

    // conc=1: do not wait for the RAM side to go quiet before/after the request
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic conc, output logic [DW-1:0] rdata);
        logic exp_hit;
        int   n_exp;
        int   cycles;
        int   ack_cyc;
        logic got_ack;
        exp_hit = ref_valid && (ref_tag == a[AW-1:3]);
        if (!conc) wait_idle();
        burst_addr_q.delete();
        burst_we_q.delete();
        wbeat_q.delete();
        stb = 1'b1; we = w; addr = a; data_in = d;
        got_ack = 1'b0; cycles = 0; ack_cyc = 0; rdata = '0;
        while (!got_ack && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (ack) begin
                got_ack = 1'b1;
                rdata   = data_out;
                ack_cyc = cyc;
            end
        end
        stb = 1'b0; we = 1'b0;
        txn_count++;
        check_val("ack_seen", 64'(got_ack), 64'd1);
        @(negedge clk);
        check_val("ack_pulse", 64'(ack), 64'd0);
        if (!conc) wait_idle();

        if (w) ref_mem[a] = d;
        ref_valid = 1'b1;
        ref_tag   = a[AW-1:3];

        n_exp = w ? (exp_hit ? 1 : 2) : (exp_hit ? 0 : 1);
        check_val("burst_count", 64'(burst_addr_q.size()), 64'(n_exp));
        if (burst_addr_q.size() == n_exp) begin
            for (int i = 0; i < n_exp; i++) begin
                check_val("burst_addr", 64'(burst_addr_q[i]), 64'(a));
                check_val("burst_we", 64'(burst_we_q[i]), 64'(w && i == n_exp - 1));
            end
        end
        if (!w) begin
            check_val("rd_data", 64'(rdata), 64'(ref_rd(a)));
            if (exp_hit) begin
                if (!conc) check_val("hit_latency", 64'(cycles), 64'd1);
                else       check_val("hit_after_fill", 64'(ack_cyc > last_cyc), 64'd1);
            end else begin
`ifdef CRITICAL_WORD_FIRST_EN
                check_val("miss_ack_cwf", 64'(ack_cyc), 64'(beat0_cyc));
`else
                check_val("miss_ack_last", 64'(ack_cyc), 64'(last_cyc));
`endif
            end
        end else begin
            check_val("wb_beats", 64'(wbeat_q.size()), 64'd8);
            if (wbeat_q.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    logic [AW-1:0] wa;
                    wa = {a[AW-1:3], a[2:0] + 3'(k)};
                    check_val("wb_data", 64'(wbeat_q[k]), 64'(ref_rd(wa)));
                end
            end
            check_val("wr_ack_last", 64'(ack_cyc), 64'(last_cyc));
        end
        $display("txn %0d we=%0b addr=0x%06h hit=%0b rdata=0x%08h cycles=%0d",
                 txn_count, w, a, exp_hit, rdata, cycles);
    endtask

    initial begin : main
        logic [DW-1:0] rd;
        int acks0;
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0; stray = 1'b0;
        ref_valid = 1'b0; ref_tag = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ack", 64'(ack), 64'd0);
        check_val("rst_ram_stb", 64'(ram_stb), 64'd0);
        check_val("rst_ram_we", 64'(ram_we), 64'd0);
        check_val("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_val("rst_data_out", 64'(data_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b0, 22'h000000, '0, 1'b0, rd);
        check_val("word0_pattern", 64'(rd), 64'hF8701E0F);
        txn(1'b0, 22'h000005, '0, 1'b0, rd);
        txn(1'b0, 22'h00000B, '0, 1'b0, rd);
        txn(1'b0, 22'h000008, '0, 1'b0, rd);

        txn(1'b0, 22'h000000, '0, 1'b0, rd);
        txn(1'b1, 22'h000003, 32'h12345678, 1'b0, rd);
        if (wbeat_q.size() > 0) check_val("wb_first_beat", 64'(wbeat_q[0]), 64'h12345678);
        txn(1'b0, 22'h000003, '0, 1'b0, rd);
        check_val("rd_after_wr", 64'(rd), 64'h12345678);

        txn(1'b1, 22'h000006, 32'hAAAA5555, 1'b0, rd);
        txn(1'b1, 22'h000006, 32'h0BADF00D, 1'b0, rd);
        txn(1'b0, 22'h000006, '0, 1'b0, rd);
        check_val("last_write_wins", 64'(rd), 64'h0BADF00D);

        txn(1'b1, 22'h000040, 32'hCAFEF00D, 1'b0, rd);

        stray = 1'b1;
        repeat (4) @(negedge clk);
        check_val("stray_issued", 64'(stray), 64'd0);
        txn(1'b0, 22'h000040, '0, 1'b0, rd);
        txn(1'b0, 22'h000041, '0, 1'b0, rd);

        // Reset in the middle of a fill
        wait_idle();
        acks0 = ack_total;
        stb = 1'b1; we = 1'b0; addr = 22'h0002A5;
        for (int i = 0; i < 200 && !(busy && beat_k >= 4); i++) @(negedge clk);
        check_val("reach_beat4", 64'(busy && beat_k >= 4), 64'd1);
        rst = 1'b1; stb = 1'b0;
        @(negedge clk);
        check_val("rst_mid_stb", 64'(ram_stb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
`ifdef CRITICAL_WORD_FIRST_EN
        txn_count++;
        check_val("rst_mid_acks", 64'(ack_total), 64'(acks0 + 1));
`else
        check_val("rst_mid_acks", 64'(ack_total), 64'(acks0));
`endif
        check_val("rst_mid_stb_after", 64'(ram_stb), 64'd0);
        ref_valid = 1'b0;
        txn(1'b0, 22'h0002A5, '0, 1'b0, rd);

`ifdef CRITICAL_WORD_FIRST_EN
        txn(1'b0, 22'h000181, '0, 1'b1, rd);
        txn(1'b0, 22'h000186, '0, 1'b1, rd);
        wait_idle();
`endif

        for (int t = 0; t < 60; t++) begin
            logic [AW-4:0] ln;
            logic [AW-1:0] ra;
            case ($urandom_range(0, 3))
                0:       ln = '0;
                1:       ln = (AW-3)'(1);
                2:       ln = (AW-3)'(8);
                default: ln = (AW-3)'($urandom);
            endcase
            ra = {ln, 3'($urandom)};
            txn(1'($urandom_range(0, 1)), ra, $urandom, 1'b0, rd);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check_val("stb_during_burst", 64'(stb_viol), 64'd0);
        check_val("ack_total", 64'(ack_total), 64'(txn_count));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
